serial_pattern_detector: RTL
============================

SERIAL_PATTERN_DETECTOR -- requirements
Module: serial_pattern_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the detected pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, giving the target pattern, MSB oldest bit, width WIDTH.
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the match-counter width.
REQ-004 The block SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST_L  input  1  reset; asynchronous and active-low.
REQ-006 The block SHALL have port D  input  1  serial data bit, sampled each enabled rising CLK edge.
REQ-007 The block SHALL have port EN  input  1  sample enable; 0 freezes the datapath.
REQ-008 The block SHALL have port CLR  input  1  synchronous clear, active-high.
REQ-009 The block SHALL have port Q  output  1  registered copy of the last sampled D.
REQ-010 The block SHALL have port SHIFT  output  WIDTH  last WIDTH sampled bits, bit 0 newest.
REQ-011 The block SHALL have port READY  output  1  high once WIDTH bits have been captured since reset or clear.
REQ-012 The block SHALL have port MATCH  output  1  one-cycle pulse marking a pattern hit.
REQ-013 The block SHALL have port COUNT  output  CNT_W  saturating number of hits.

Function
REQ-014 The block SHALL register all outputs; it SHALL have no combinational path from D to any output.
REQ-015 The block SHALL implement a two-state FSM: FILL (READY=0) and RUN (READY=1).
REQ-016 In FILL, an internal fill counter SHALL increment on each enabled edge; the FSM SHALL move to RUN on the edge that captures the WIDTH-th bit.
REQ-017 RUN SHALL be left only by reset or CLR, both of which SHALL return the FSM to FILL with the fill counter at 0.
REQ-018 On an enabled edge (EN=1, CLR=0), Q SHALL take D and SHIFT SHALL take {SHIFT[WIDTH-2:0], D}.
REQ-019 On an enabled edge, MATCH SHALL be set to 1 when the new SHIFT value equals PATTERN and the edge leaves the FSM in RUN (including the FILL->RUN edge); otherwise MATCH SHALL be set to 0.
REQ-020 MATCH latency SHALL be exactly one edge: the hit is visible in the cycle following the edge that sampled the last pattern bit.
REQ-021 Detection SHALL be overlapping: bits of one hit SHALL be reusable by the next hit.
REQ-022 COUNT SHALL increment on the same edge that sets MATCH=1, and SHALL saturate at 2^CNT_W-1 (it SHALL NOT wrap); MATCH SHALL still pulse while COUNT is saturated.
REQ-023 When EN=0 and CLR=0, Q, SHIFT, COUNT, the FSM state and the fill counter SHALL hold, and MATCH SHALL be 0 after that edge.
REQ-024 CLR=1 SHALL take priority over EN; on that edge Q, SHIFT, MATCH and COUNT SHALL all go to 0.
REQ-025 The block SHALL sample D at every edge while EN=1, without a gap (one bit per cycle throughput).

Reset
REQ-026 RST_L=0 SHALL immediately, independent of CLK, force Q=0, SHIFT=0, MATCH=0, COUNT=0, READY=0, the FSM to FILL and the fill counter to 0.
REQ-027 While RST_L=0, the block SHALL ignore CLK edges.
REQ-028 The first capture after deassertion SHALL occur on the first rising CLK edge at which RST_L=1.
REQ-029 An assertion of reset in the middle of a partial pattern SHALL discard that partial pattern entirely.

Verification
REQ-030 The bench SHALL cover this scenario: defaults, 10 ns clock, EN=1, D=1,0,1,1 on edges 1-4 after reset -> READY=1 and MATCH=1 after edge 4, SHIFT=4'b1011, COUNT=1, Q=1.
REQ-031 The bench SHALL cover this scenario: D stream 1,0,1,1,0,1,1 -> MATCH pulses after edges 4 and 7 only, and COUNT=2.
REQ-032 The bench SHALL cover this scenario: PATTERN=4'b0000, D=0 continuously after reset -> MATCH=0 after edges 1-3, MATCH=1 from edge 4 onward.
REQ-033 The bench SHALL cover this scenario: send 1,0,1, drive RST_L low for 7 ns at mid-cycle, then send 1 -> outputs are 0 immediately at reset assertion, and there is no MATCH after the 1; the pattern 1,0,1,1 then gives a MATCH.
REQ-034 The bench SHALL cover this scenario: send 1,0,1, hold EN=0 for 3 edges with D=0, then EN=1 and D=1 -> SHIFT holds 4'b0101 during the hold, MATCH=1 after the resume edge.
REQ-035 The bench SHALL cover this scenario: CNT_W=2 with 5 overlapping hits -> COUNT goes 1,2,3,3,3, and MATCH pulses all 5 times; CLR=1 with EN=1 -> everything 0, READY=0.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in one bit per enabled clock, flags a
// match of the last WIDTH bits against PATTERN (overlapping), and keeps a
// saturating hit count. All outputs come straight from flops.
//
// Ports:
//   CLK    - clock, rising edge
//   RST_L  - asynchronous active-low reset
//   D      - serial data in
//   EN     - sample enable; low freezes the datapath
//   CLR    - synchronous clear, wins over EN
//   Q      - last sampled bit
//   SHIFT  - last WIDTH sampled bits, bit 0 newest
//   READY  - WIDTH bits captured since reset/clear
//   MATCH  - one-cycle hit pulse
//   COUNT  - saturating hit count
module serial_pattern_detector #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  PATTERN = WIDTH'(4'b1011),
    parameter int unsigned       CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             D,
    input  logic             EN,
    input  logic             CLR,
    output logic             Q,
    output logic [WIDTH-1:0] SHIFT,
    output logic             READY,
    output logic             MATCH,
    output logic [CNT_W-1:0] COUNT
);

    // Fill counter spans 0..WIDTH so the increment on the last fill edge never wraps.
    localparam int unsigned FILL_W = $clog2(WIDTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_n;
    logic               q_n;
    logic [WIDTH-1:0]   shift_n;
    logic               match_n;
    logic [CNT_W-1:0]   count_n;

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state <= FILL;
            fill  <= '0;
            Q     <= 1'b0;
            SHIFT <= '0;
            MATCH <= 1'b0;
            COUNT <= '0;
        end else begin
            state <= state_n;
            fill  <= fill_n;
            Q     <= q_n;
            SHIFT <= shift_n;
            MATCH <= match_n;
            COUNT <= count_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        fill_n  = fill;
        q_n     = Q;
        shift_n = SHIFT;
        match_n = 1'b0;
        count_n = COUNT;

        if (CLR) begin
            state_n = FILL;
            fill_n  = '0;
            q_n     = 1'b0;
            shift_n = '0;
            count_n = '0;
        end else if (EN) begin
            q_n     = D;
            shift_n = {SHIFT[WIDTH-2:0], D};
            if (state == FILL) begin
                fill_n = fill + FILL_W'(1);
                if (fill == FILL_W'(WIDTH - 1)) begin
                    state_n = RUN;
                end
            end
            // A hit only counts once the window is full, including the filling edge.
            match_n = (shift_n == PATTERN) && (state_n == RUN);
            if (match_n && (COUNT != {CNT_W{1'b1}})) begin
                count_n = COUNT + CNT_W'(1);
            end
        end
    end

    assign READY = (state == RUN);

endmodule
